apb_arbiter: RTL and testbench

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_apb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB completer; all outputs registered.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES consecutive wait states.
module apb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       err0,
    output logic       err1,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic       pready,
    input  logic       pslverr,
    input  logic [7:0] prdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       gnt_q, gnt_d;
    logic       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic       done0_q, done0_d, done1_q, done1_d;
    logic       err0_q, err0_d, err1_q, err1_d;
    logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic       req_m0, req_m1, pick;
    logic       finish, fin_err, fin_load;
    logic [7:0] fin_rdata;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // A requester whose done is pulsing is still holding a stale req; keep it out.
    assign req_m0 = req0 & ~done0_q;
    assign req_m1 = req1 & ~done1_q;
    assign pick   = (req_m0 & req_m1) ? ~last_q : req_m1;

    always_comb begin
        finish    = 1'b0;
        fin_err   = pslverr;
        fin_rdata = prdata;
        fin_load  = ~pwrite_q;
        if (state_q == ACCESS) begin
            if (pready) begin
                finish = 1'b1;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                finish    = 1'b1;
                fin_err   = 1'b1;
                fin_rdata = 8'h00;
                fin_load  = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err0_d    = err0_q;
        err1_d    = err1_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_m0 | req_m1) begin
                    state_d   = SETUP;
                    gnt_d     = pick;
                    last_d    = pick;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = pick ? wr1    : wr0;
                    paddr_d   = pick ? addr1  : addr0;
                    pwdata_d  = pick ? wdata1 : wdata0;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (finish) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = 8'h00;
                    pwdata_d  = 8'h00;
                    if (gnt_q) begin
                        done1_d = 1'b1;
                        err1_d  = fin_err;
                        if (fin_load) rdata1_d = fin_rdata;
                    end else begin
                        done0_d = 1'b1;
                        err0_d  = fin_err;
                        if (fin_load) rdata0_d = fin_rdata;
                    end
                end
`ifdef APB_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 8'h00;
            pwdata_q  <= 8'h00;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 8'h00;
            rdata1_q  <= 8'h00;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed transfers plus randomized transfers against a transaction-level model.
module tb_apb_arbiter;
    logic       pclk = 1'b0;
    logic       presetn;
    logic       req0, req1, wr0, wr1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       pready, pslverr;
    logic [7:0] prdata;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference state
    int         last_gnt;
    logic [7:0] exp_rdata [2];
    logic       exp_err   [2];

    always #5 pclk = ~pclk;

    apb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic model_reset;
        last_gnt = 1;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        exp_err[0] = 1'b0;    exp_err[1] = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_err0"},   err0,   exp_err[0]);
        check({tag, "_err1"},   err1,   exp_err[1]);
        check({tag, "_rdata0"}, rdata0, exp_rdata[0]);
        check({tag, "_rdata1"}, rdata1, exp_rdata[1]);
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, "_psel"},    psel,    1'b0);
        check({tag, "_penable"}, penable, 1'b0);
        check({tag, "_pwrite"},  pwrite,  1'b0);
        check({tag, "_paddr"},   paddr,   8'h00);
        check({tag, "_pwdata"},  pwdata,  8'h00);
    endtask

    // One complete transfer from fresh request(s) to the idle cycle after done.
    task automatic run_xfer(input string tag, input logic r0, input logic r1,
                            input logic w0, input logic w1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input int waits, input logic serr, input logic [7:0] rd);
        int         win;
        logic       ew;
        logic [7:0] ea, ed;
        win = (r0 && r1) ? 1 - last_gnt : (r1 ? 1 : 0);
        ew  = win ? w1 : w0;
        ea  = win ? a1 : a0;
        ed  = win ? d1 : d0;
        wr0 = w0; wr1 = w1; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        pslverr = serr; prdata = rd; pready = 1'b0;
        req0 = r0; req1 = r1;
        tick;
        check({tag, "_setup_psel"},    psel,    1'b1);
        check({tag, "_setup_penable"}, penable, 1'b0);
        check({tag, "_setup_paddr"},   paddr,   ea);
        check({tag, "_setup_pwrite"},  pwrite,  ew);
        check({tag, "_setup_pwdata"},  pwdata,  ed);
        tick;
        check({tag, "_access_penable"}, penable, 1'b1);
        check({tag, "_access_psel"},    psel,    1'b1);
        check({tag, "_access_paddr"},   paddr,   ea);
        check({tag, "_access_pwdata"},  pwdata,  ed);
        for (int i = 0; i < waits; i++) begin
            tick;
            check({tag, "_wait_done"},    {done1, done0}, 2'b00);
            check({tag, "_wait_penable"}, penable,        1'b1);
            check({tag, "_wait_paddr"},   paddr,          ea);
        end
        pready = 1'b1;
        tick;
        last_gnt = win;
        exp_err[win] = serr;
        if (!ew) exp_rdata[win] = rd;
        check({tag, "_done"}, {done1, done0}, win ? 2'b10 : 2'b01);
        check_bus_idle({tag, "_done"});
        check_status(tag);
        req0 = 1'b0; req1 = 1'b0; pready = 1'b0;
        tick;
        check({tag, "_after_done"}, {done1, done0}, 2'b00);
        check({tag, "_after_psel"}, psel,           1'b0);
        check_status({tag, "_hold"});
    endtask

    initial begin
        presetn = 1'b0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        pready = 0; pslverr = 0; prdata = 0;
        model_reset();
        #12;
        check({"rst_done"}, {done1, done0}, 2'b00);
        check_bus_idle("rst");
        check_status("rst");
        presetn = 1'b1;
        tick;

        // Directed: write from 0, read from 1 with two wait states, error then clean.
        run_xfer("wr0", 1, 0, 1, 0, 8'h10, 8'h00, 8'hA5, 8'h00, 0, 0, 8'h00);
        run_xfer("rd1", 0, 1, 0, 0, 8'h00, 8'h20, 8'h00, 8'h00, 2, 0, 8'h3C);
        run_xfer("err0", 1, 0, 0, 0, 8'h33, 8'h00, 8'h00, 8'h00, 1, 1, 8'h77);
        run_xfer("clean0", 1, 0, 1, 0, 8'h34, 8'h00, 8'h5A, 8'h00, 0, 0, 8'hEE);
        run_xfer("tie_a", 1, 1, 0, 1, 8'h41, 8'h42, 8'h01, 8'h02, 0, 0, 8'h99);
        run_xfer("tie_b", 1, 1, 0, 1, 8'h43, 8'h44, 8'h03, 8'h04, 1, 0, 8'h98);

        // Both requests held continuously: strict alternation, one idle cycle each.
        addr0 = 8'h40; addr1 = 8'h80; wr0 = 0; wr1 = 0; pslverr = 0; pready = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int win;
            win = 1 - last_gnt;
            prdata = 8'($urandom);
            tick;
            check("rr_psel",  psel,  1'b1);
            check("rr_paddr", paddr, win ? 8'h80 : 8'h40);
            tick;
            check("rr_penable", penable, 1'b1);
            tick;
            last_gnt = win;
            exp_err[win] = 1'b0;
            exp_rdata[win] = prdata;
            check("rr_done", {done1, done0}, win ? 2'b10 : 2'b01);
            check("rr_idle_psel", psel, 1'b0);
            check_status("rr");
        end
        req0 = 1'b0; req1 = 1'b0; pready = 1'b0;
        tick;
        check("rr_end_psel", psel, 1'b0);
        check("rr_end_done", {done1, done0}, 2'b00);

        // Reset during ACCESS: bus drops at once, no done, pointer back to 1.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h66; pready = 1'b0;
        tick;
        tick;
        tick;
        check("prerst_penable", penable, 1'b1);
        #2 presetn = 1'b0;
        #1;
        model_reset();
        check("midrst_psel",    psel,    1'b0);
        check("midrst_penable", penable, 1'b0);
        check("midrst_done",    {done1, done0}, 2'b00);
        check_status("midrst");
        req0 = 1'b0;
        #2 presetn = 1'b1;
        tick;
        check("postrst_psel", psel, 1'b0);
        check("postrst_done", {done1, done0}, 2'b00);
        run_xfer("postrst_tie", 1, 1, 0, 0, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 8'hC3);

`ifdef APB_ARB_TIMEOUT_EN
        // Completer never answers: abort after four ACCESS samples.
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h55; prdata = 8'hFF; pready = 1'b0;
        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("to_wait_done", {done1, done0}, 2'b00);
        end
        tick;
        last_gnt = 0; exp_err[0] = 1'b1; exp_rdata[0] = 8'h00;
        check("to_done", {done1, done0}, 2'b01);
        check_bus_idle("to");
        check_status("to");
        req0 = 1'b0;
        tick;
`else
        run_xfer("longwait", 0, 1, 0, 0, 8'h00, 8'h5C, 8'h00, 8'h00, 20, 0, 8'hB7);
`endif

        // Randomized transfers
        for (int n = 0; n < 24; n++) begin
            int r;
            r = int'($urandom_range(1, 3));
            run_xfer("rand", r[0], r[1], 1'($urandom), 1'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
